bus_arbiter: RTL and testbench

Two-master, round-robin arbiter for the native valid/ready memory bus. It lets the CPU core (m0) and a second bus master such as a future DMA engine (m1) share the single slave port that decodes SRAM and the peripheral registers. Each granted access is registered once toward the slave. The response is returned to the granted master only. A stalled slave access is aborted by a programmable timeout with an error response.

---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: widths, FSM encoding and
// the error read-data pattern returned on an aborted access.
package bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] BUS_ERR_RDATA = 32'hFFFF_FFFF;

    // Round-robin pick: returns 1 when m1 should be granted. On a tie the
    // master that was not granted last wins.
    function automatic logic pick_m1(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the valid/ready memory bus with a
// registered slave request and a programmable abort timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy,
    output logic              timeout_evt
);

    // One spare count value so the counter can hold TIMEOUT and still saturate.
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
    localparam bit TMO_EN = (TIMEOUT != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state, state_nxt;
    logic              last;
    logic              gnt;
    logic              aborted;
    logic [CNT_W-1:0]  cnt;

    logic              grant_sel;
    logic              take_grant;
    logic              slave_done;
    logic              tmo_hit;
    logic              enter_resp;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              m0_ready_nxt, m1_ready_nxt;
    logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
    logic              m0_err_nxt, m1_err_nxt;
    logic              busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (m0_valid || m1_valid) state_nxt = ST_GRANT;
            ST_GRANT: if (s_ready || (TMO_EN && cnt == TMO_VAL)) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = aborted ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Decoded strobes and the next values of every registered output.
    always_comb begin
        grant_sel    = pick_m1(m0_valid, m1_valid, last);
        take_grant   = (state == ST_IDLE) && (m0_valid || m1_valid);
        slave_done   = (state == ST_GRANT) && s_ready;
        tmo_hit      = (state == ST_GRANT) && !s_ready && TMO_EN && (cnt == TMO_VAL);
        enter_resp   = slave_done || tmo_hit;
        resp_rdata   = tmo_hit ? BUS_ERR_RDATA : s_rdata;
        sel_addr     = grant_sel ? m1_addr  : m0_addr;
        sel_wdata    = grant_sel ? m1_wdata : m0_wdata;
        sel_wstrb    = grant_sel ? m1_wstrb : m0_wstrb;
        m0_ready_nxt = enter_resp && !gnt;
        m1_ready_nxt = enter_resp && gnt;
        m0_rdata_nxt = m0_ready_nxt ? resp_rdata : '0;
        m1_rdata_nxt = m1_ready_nxt ? resp_rdata : '0;
        m0_err_nxt   = tmo_hit && !gnt;
        m1_err_nxt   = tmo_hit && gnt;
        busy_nxt     = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last        <= 1'b1;
            gnt         <= 1'b0;
            aborted     <= 1'b0;
            cnt         <= '0;
            s_valid     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            m0_err      <= 1'b0;
            m1_err      <= 1'b0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            if (take_grant) begin
                gnt     <= grant_sel;
                s_valid <= 1'b1;
                s_addr  <= sel_addr;
                s_wdata <= sel_wdata;
                s_wstrb <= sel_wstrb;
                cnt     <= '0;
            end
            if (enter_resp) begin
                s_valid <= 1'b0;
                aborted <= tmo_hit;
            end
            if (slave_done) begin
                last <= gnt;
            end
            if ((state == ST_GRANT) && !enter_resp) begin
                cnt <= sat_inc(cnt);
            end
            m0_ready    <= m0_ready_nxt;
            m1_ready    <= m1_ready_nxt;
            m0_rdata    <= m0_rdata_nxt;
            m1_rdata    <= m1_rdata_nxt;
            m0_err      <= m0_err_nxt;
            m1_err      <= m1_err_nxt;
            busy        <= busy_nxt;
            timeout_evt <= tmo_hit;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a TIMEOUT=4 instance for most scenarios and a
// TIMEOUT=0 instance on the same inputs for the long-stall scenario.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, busy, timeout_evt;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    logic        nt_m0_ready, nt_m1_ready, nt_m0_err, nt_m1_err;
    logic [31:0] nt_m0_rdata, nt_m1_rdata;
    logic        nt_s_valid, nt_busy, nt_timeout_evt;
    logic [31:0] nt_s_addr, nt_s_wdata;
    logic [3:0]  nt_s_wstrb;

    int n_chk = 0;
    int n_err = 0;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .busy(busy), .timeout_evt(timeout_evt)
    );

    bus_arbiter #(.TIMEOUT(0)) dut_nt (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(nt_m0_ready), .m0_rdata(nt_m0_rdata), .m0_err(nt_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(nt_m1_ready), .m1_rdata(nt_m1_rdata), .m1_err(nt_m1_err),
        .s_valid(nt_s_valid), .s_addr(nt_s_addr), .s_wdata(nt_s_wdata), .s_wstrb(nt_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .busy(nt_busy), .timeout_evt(nt_timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int g);
        return (g == 1) ? m1_ready : m0_ready;
    endfunction

    function automatic logic [31:0] rdat(input int g);
        return (g == 1) ? m1_rdata : m0_rdata;
    endfunction

    function automatic logic errv(input int g);
        return (g == 1) ? m1_err : m0_err;
    endfunction

    task automatic clear_inputs();
        m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 0; s_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_valid"}, {31'd0, s_valid}, 0);
        chk({tag, ".s_addr"}, s_addr, 0);
        chk({tag, ".s_wdata"}, s_wdata, 0);
        chk({tag, ".s_wstrb"}, {28'd0, s_wstrb}, 0);
        chk({tag, ".m0_ready"}, {31'd0, m0_ready}, 0);
        chk({tag, ".m1_ready"}, {31'd0, m1_ready}, 0);
        chk({tag, ".m0_rdata"}, m0_rdata, 0);
        chk({tag, ".m1_rdata"}, m1_rdata, 0);
        chk({tag, ".m0_err"}, {31'd0, m0_err}, 0);
        chk({tag, ".m1_err"}, {31'd0, m1_err}, 0);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
        chk({tag, ".timeout_evt"}, {31'd0, timeout_evt}, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // Valids are already set by the caller; master g is expected to win the
    // edge E0. The slave answers one cycle after E1 with sdata.
    task automatic expect_grant(input int g, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [31:0] sdata,
                                input bit rerise, input string tag);
        int o;
        o = 1 - g;
        tick(); // E0
        chk({tag, ".e0.s_valid"}, {31'd0, s_valid}, 1);
        chk({tag, ".e0.s_addr"}, s_addr, addr);
        chk({tag, ".e0.s_wdata"}, s_wdata, wdata);
        chk({tag, ".e0.s_wstrb"}, {28'd0, s_wstrb}, {28'd0, wstrb});
        chk({tag, ".e0.busy"}, {31'd0, busy}, 1);
        chk({tag, ".e0.ready"}, {30'd0, m1_ready, m0_ready}, 0);
        tick(); // E1
        chk({tag, ".e1.ready"}, {30'd0, m1_ready, m0_ready}, 0);
        s_ready = 1;
        s_rdata = sdata;
        tick(); // E2
        s_ready = 0;
        s_rdata = '0;
        chk({tag, ".e2.ready"}, {31'd0, rdy(g)}, 1);
        chk({tag, ".e2.rdata"}, rdat(g), sdata);
        chk({tag, ".e2.err"}, {31'd0, errv(g)}, 0);
        chk({tag, ".e2.other_ready"}, {31'd0, rdy(o)}, 0);
        chk({tag, ".e2.other_rdata"}, rdat(o), 0);
        chk({tag, ".e2.s_valid"}, {31'd0, s_valid}, 0);
        chk({tag, ".e2.tmo"}, {31'd0, timeout_evt}, 0);
        if (g == 1) m1_valid = 0; else m0_valid = 0;
        tick(); // E3
        chk({tag, ".e3.ready"}, {30'd0, m1_ready, m0_ready}, 0);
        chk({tag, ".e3.busy"}, {31'd0, busy}, 0);
        if (rerise) begin
            if (g == 1) m1_valid = 1; else m0_valid = 1;
        end
    endtask

    initial begin
        int bad_busy, bad_ready, bad_evt;
        clear_inputs();
        rst_n = 0;
        tick();
        chk_all_zero("reset");
        tick();
        rst_n = 1;

        // Single read from m0 against a one-cycle slave.
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'b0000;
        expect_grant(0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, "rd_m0");

        // Both masters requesting continuously: grants alternate starting at m0.
        do_reset();
        m0_valid = 1; m0_addr = 32'h200; m0_wdata = 32'hAA; m0_wstrb = 4'b1100;
        m1_valid = 1; m1_addr = 32'h300; m1_wdata = 32'h55; m1_wstrb = 4'b0001;
        expect_grant(0, 32'h200, 32'hAA, 4'b1100, 32'h1111_0000, 1, "rr0");
        expect_grant(1, 32'h300, 32'h55, 4'b0001, 32'h2222_0000, 1, "rr1");
        expect_grant(0, 32'h200, 32'hAA, 4'b1100, 32'h3333_0000, 1, "rr2");
        expect_grant(1, 32'h300, 32'h55, 4'b0001, 32'h4444_0000, 0, "rr3");
        m0_valid = 0;

        // Silent slave with TIMEOUT=4: abort after counter reaches 4.
        do_reset();
        m0_valid = 1; m0_addr = 32'h20;
        tick(); // E0
        chk("tmo.e0.s_valid", {31'd0, s_valid}, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("tmo.e%0d.ready", i), {31'd0, m0_ready}, 0);
            chk($sformatf("tmo.e%0d.evt", i), {31'd0, timeout_evt}, 0);
            chk($sformatf("tmo.e%0d.s_valid", i), {31'd0, s_valid}, 1);
        end
        tick(); // E5: abort
        chk("tmo.abort.ready", {31'd0, m0_ready}, 1);
        chk("tmo.abort.err", {31'd0, m0_err}, 1);
        chk("tmo.abort.rdata", m0_rdata, 32'hFFFF_FFFF);
        chk("tmo.abort.evt", {31'd0, timeout_evt}, 1);
        chk("tmo.abort.s_valid", {31'd0, s_valid}, 0);
        chk("tmo.abort.m1_ready", {31'd0, m1_ready}, 0);
        m0_valid = 0;
        s_ready = 1; s_rdata = 32'h1234_5678;
        tick(); // FLUSH
        chk("tmo.flush.busy", {31'd0, busy}, 1);
        chk("tmo.flush.ready", {31'd0, m0_ready}, 0);
        chk("tmo.flush.err", {31'd0, m0_err}, 0);
        chk("tmo.flush.evt", {31'd0, timeout_evt}, 0);
        chk("tmo.flush.s_valid", {31'd0, s_valid}, 0);
        tick(); // IDLE, late s_ready must not have produced anything
        s_ready = 0; s_rdata = '0;
        chk("tmo.idle.busy", {31'd0, busy}, 0);
        chk("tmo.idle.ready", {30'd0, m1_ready, m0_ready}, 0);
        tick();
        chk("tmo.idle2.s_valid", {31'd0, s_valid}, 0);

        // TIMEOUT=0 instance: slave answers after 1000 cycles, no abort.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0000_0ABC; m0_wdata = 32'h0BAD_F00D; m0_wstrb = 4'b1111;
        tick(); // E0
        chk("nt.e0.s_valid", {31'd0, nt_s_valid}, 1);
        chk("nt.e0.s_addr", nt_s_addr, 32'h0000_0ABC);
        chk("nt.e0.s_wdata", nt_s_wdata, 32'h0BAD_F00D);
        chk("nt.e0.s_wstrb", {28'd0, nt_s_wstrb}, 32'hF);
        bad_busy = 0; bad_ready = 0; bad_evt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (nt_busy !== 1'b1 || nt_s_valid !== 1'b1) bad_busy++;
            if (nt_m0_ready !== 1'b0 || nt_m0_err !== 1'b0) bad_ready++;
            if (nt_timeout_evt !== 1'b0) bad_evt++;
        end
        chk("nt.wait.busy_low_cycles", bad_busy, 0);
        chk("nt.wait.ready_cycles", bad_ready, 0);
        chk("nt.wait.evt_cycles", bad_evt, 0);
        s_ready = 1; s_rdata = 32'hCAFE_0001;
        tick();
        s_ready = 0; s_rdata = '0;
        m0_valid = 0;
        chk("nt.resp.ready", {31'd0, nt_m0_ready}, 1);
        chk("nt.resp.rdata", nt_m0_rdata, 32'hCAFE_0001);
        chk("nt.resp.err", {31'd0, nt_m0_err}, 0);
        chk("nt.resp.evt", {31'd0, nt_timeout_evt}, 0);
        chk("nt.resp.busy", {31'd0, nt_busy}, 1);
        chk("nt.resp.m1", {nt_m1_rdata[29:0], nt_m1_err, nt_m1_ready}, 0);
        tick();
        chk("nt.idle.busy", {31'd0, nt_busy}, 0);
        chk("nt.idle.ready", {31'd0, nt_m0_ready}, 0);

        // Reset asserted mid-access.
        do_reset();
        m0_valid = 1; m0_addr = 32'h30; m0_wdata = 32'h77; m0_wstrb = 4'b0011;
        tick(); // E0
        chk("rst_mid.grant.s_valid", {31'd0, s_valid}, 1);
        #2 rst_n = 0;
        #1;
        chk_all_zero("rst_mid.async");
        m0_addr = 32'h40; m0_wdata = 32'h0; m0_wstrb = 4'b0000;
        m1_valid = 1; m1_addr = 32'h50; m1_wdata = 32'h99; m1_wstrb = 4'b1000;
        tick();
        chk_all_zero("rst_mid.hold");
        rst_n = 1;
        expect_grant(0, 32'h40, 32'h0, 4'h0, 32'h0000_4040, 0, "rst_mid.tie");
        expect_grant(1, 32'h50, 32'h99, 4'b1000, 32'h0000_5050, 0, "rst_mid.m1");

        // m1 alone for ten accesses; m0 outputs must remain quiet.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            m1_valid = 1;
            m1_addr  = 32'h1000 + 32'(i * 4);
            m1_wdata = 32'(i);
            m1_wstrb = 4'hF;
            expect_grant(1, 32'h1000 + 32'(i * 4), 32'(i), 4'hF, 32'hA000_0000 + 32'(i), 0,
                         $sformatf("m1_only%0d", i));
            chk($sformatf("m1_only%0d.m0_quiet", i), {m0_rdata[29:0], m0_err, m0_ready}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
